// File: rtl/pix_box_downsampler.sv
// Raster-stream box downsampler: crops a window, averages BLKxBLK blocks, writes one pixel per block.
// Define BOX_DS_BINARIZE_EN to output (avg >= thresh) ? all-ones : 0 instead of the average.
module pix_box_downsampler #(
  parameter int PIX_W    = 8,
  parameter int COORD_W  = 16,
  parameter int OUT_W    = 28,
  parameter int OUT_H    = 28,
  parameter int LOG2_BLK = 3,
  parameter int ADDR_W   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COORD_W-1:0] win_x0,
  input  logic [COORD_W-1:0] win_y0,
  input  logic [PIX_W-1:0]   thresh,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [PIX_W-1:0]   pix_data,
  output logic               busy,
  output logic               done,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [PIX_W-1:0]   wr_data
);
  localparam int BLK   = 1 << LOG2_BLK;
  localparam int ACC_W = PIX_W + 2*LOG2_BLK;
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam logic [COORD_W-1:0] WIN_WC   = COORD_W'(OUT_W*BLK);
  localparam logic [COORD_W-1:0] WIN_HC   = COORD_W'(OUT_H*BLK);
  localparam logic [COORD_W-1:0] BLK_MASK = COORD_W'(BLK-1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [COORD_W-1:0]       x0_q, x0_d, y0_q, y0_d;
  logic [OUT_W-1:0][ACC_W-1:0] acc_q, acc_d;
  logic                     wr_en_q, wr_en_d, done_q, done_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]         wr_data_q, wr_data_d;

  logic [COORD_W-1:0] rx, ry;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic               in_win, origin, blk_end, last_blk, hit;
  logic [ACC_W-1:0]   blk_sum;
  logic [PIX_W-1:0]   avg;

  // Unsigned wrap of rx/ry makes the upper bound check safe once pix >= origin.
  assign rx       = pix_x - x0_q;
  assign ry       = pix_y - y0_q;
  assign in_win   = (pix_x >= x0_q) && (rx < WIN_WC) && (pix_y >= y0_q) && (ry < WIN_HC);
  assign origin   = (pix_x == x0_q) && (pix_y == y0_q);
  assign col      = rx[LOG2_BLK +: CW];
  assign row      = ry[LOG2_BLK +: RW];
  assign blk_end  = ((rx & BLK_MASK) == BLK_MASK) && ((ry & BLK_MASK) == BLK_MASK);
  assign last_blk = (col == CW'(OUT_W-1)) && (row == RW'(OUT_H-1));
  assign hit      = pix_valid && in_win &&
                    ((state_q == S_CAPT) || ((state_q == S_ARM) && origin));
  // The origin pixel starts a fresh frame, so it never sees stale accumulator content.
  assign blk_sum  = (origin ? '0 : acc_q[col]) + ACC_W'(pix_data);
  assign avg      = PIX_W'(blk_sum >> (2*LOG2_BLK));

  // Held high through the done cycle so it drops one cycle after done.
  assign busy = (state_q != S_IDLE) || done_q;

`ifndef BOX_DS_BINARIZE_EN
  logic unused_thresh;
  assign unused_thresh = ^thresh;
`endif

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    acc_d     = acc_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (state_q == S_IDLE) begin
      if (start && !busy) begin
        x0_d    = win_x0;
        y0_d    = win_y0;
        acc_d   = '0;
        state_d = S_ARM;
      end
    end else if (hit) begin
      if (origin) begin
        acc_d   = '0;
        state_d = S_CAPT;
      end
      if (blk_end) begin
        acc_d[col] = '0;
        wr_en_d    = 1'b1;
        wr_addr_d  = ADDR_W'(row) * ADDR_W'(OUT_W) + ADDR_W'(col);
`ifdef BOX_DS_BINARIZE_EN
        wr_data_d  = (avg >= thresh) ? '1 : '0;
`else
        wr_data_d  = avg;
`endif
        if (last_blk) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end else begin
        acc_d[col] = blk_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      acc_q     <= acc_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign done    = done_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
endmodule

// File: tb/tb_pix_box_downsampler.sv
// Directed bench for pix_box_downsampler: default 28x28/8, a 2x2/8 instance and a 4x3/2 instance share one pixel bus.
module tb_pix_box_downsampler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] win_x0 = 16'd100, win_y0 = 16'd50;
  logic [7:0]  thresh = 8'h40;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_x = '0, pix_y = '0;
  logic [7:0]  pix_data = '0;

  logic rst_a = 1'b0, start_a = 1'b0, busy_a, done_a, wr_en_a;
  logic [9:0] wr_addr_a; logic [7:0] wr_data_a;
  logic rst_m = 1'b0, start_m = 1'b0, busy_m, done_m, wr_en_m;
  logic [1:0] wr_addr_m; logic [7:0] wr_data_m;
  logic rst_s = 1'b0, start_s = 1'b0, busy_s, done_s, wr_en_s;
  logic [3:0] wr_addr_s; logic [7:0] wr_data_s;

  pix_box_downsampler u_dut (
    .clk(clk), .rst_n(rst_a), .start(start_a), .win_x0(win_x0), .win_y0(win_y0),
    .thresh(thresh), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .busy(busy_a), .done(done_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a));

  pix_box_downsampler #(.OUT_W(2), .OUT_H(2), .LOG2_BLK(3), .ADDR_W(2)) u_mid (
    .clk(clk), .rst_n(rst_m), .start(start_m), .win_x0(win_x0), .win_y0(win_y0),
    .thresh(thresh), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .busy(busy_m), .done(done_m), .wr_en(wr_en_m), .wr_addr(wr_addr_m), .wr_data(wr_data_m));

  pix_box_downsampler #(.OUT_W(4), .OUT_H(3), .LOG2_BLK(1), .ADDR_W(4)) u_sml (
    .clk(clk), .rst_n(rst_s), .start(start_s), .win_x0(win_x0), .win_y0(win_y0),
    .thresh(thresh), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .busy(busy_s), .done(done_s), .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s));

  int n_chk = 0, n_fail = 0;

  typedef struct {int addr; int data; int done;} wr_t;
  wr_t wq_a[$], wq_m[$], wq_s[$];
  int   ndone_a = 0, ndone_m = 0, ndone_s = 0;
  logic busy_at_done_a = 1'b0, busy_after_done_a = 1'b1, prev_done_a = 1'b0;

  always @(negedge clk) begin
    if (wr_en_a) wq_a.push_back('{int'(wr_addr_a), int'(wr_data_a), int'(done_a)});
    if (wr_en_m) wq_m.push_back('{int'(wr_addr_m), int'(wr_data_m), int'(done_m)});
    if (wr_en_s) wq_s.push_back('{int'(wr_addr_s), int'(wr_data_s), int'(done_s)});
    if (prev_done_a) busy_after_done_a = busy_a;
    if (done_a) begin ndone_a++; busy_at_done_a = busy_a; end
    if (done_m) ndone_m++;
    if (done_s) ndone_s++;
    prev_done_a = done_a;
  end

  function automatic logic [7:0] bin(input int v);
`ifdef BOX_DS_BINARIZE_EN
    return (v >= 'h40) ? 8'hFF : 8'h00;
`else
    return 8'(v);
`endif
  endfunction

  function automatic logic [7:0] pix_val(input int pat, input int x, input int y);
    int rx, ry, bx, by;
    rx = x - 100; ry = y - 50; bx = rx >>> 3; by = ry >>> 3;
    case (pat)
      0: return 8'h80;
      1: return (((bx + by) & 1) != 0) ? 8'hFF : 8'h00;
      2: begin
        if (bx == 0 && by == 0) return (rx >= 0 && rx < 4 && ry >= 0 && ry < 4) ? 8'hFF : 8'h00;
        if (bx == 1 && by == 0) return 8'h3F;
        if (bx == 0 && by == 1) return 8'h40;
        return 8'h00;
      end
      default: return 8'(rx + ry);
    endcase
  endfunction

  task automatic drive_frame(input int pat, input int xl, input int xh, input int yl, input int yh,
                             input int sy, input logic [2:0] smask);
    for (int y = yl; y < yh; y++)
      for (int x = xl; x < xh; x++) begin
        @(negedge clk);
        pix_valid = 1'b1; pix_x = 16'(x); pix_y = 16'(y); pix_data = pix_val(pat, x, y);
        start_a = (x == xl && y == sy) && smask[0];
        start_m = (x == xl && y == sy) && smask[1];
        start_s = (x == xl && y == sy) && smask[2];
      end
    @(negedge clk);
    pix_valid = 1'b0; start_a = 1'b0; start_m = 1'b0; start_s = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start(input int which);
    @(negedge clk);
    start_a = (which == 0); start_m = (which == 1); start_s = (which == 2);
    @(negedge clk);
    start_a = 1'b0; start_m = 1'b0; start_s = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if ({busy_a, done_a, wr_en_a, wr_addr_a, wr_data_a} !== '0) begin
      n_fail++; $display("FAIL reset_a: got %b want 0", {busy_a, done_a, wr_en_a, wr_addr_a, wr_data_a}); end
    n_chk++; if ({busy_m, done_m, wr_en_m, wr_addr_m, wr_data_m} !== '0) begin
      n_fail++; $display("FAIL reset_m: got %b want 0", {busy_m, done_m, wr_en_m, wr_addr_m, wr_data_m}); end
    n_chk++; if ({busy_s, done_s, wr_en_s, wr_addr_s, wr_data_s} !== '0) begin
      n_fail++; $display("FAIL reset_s: got %b want 0", {busy_s, done_s, wr_en_s, wr_addr_s, wr_data_s}); end
    rst_a = 1'b1; rst_m = 1'b1; rst_s = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (busy_a !== 1'b0 || wr_en_a !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: busy=%b wr_en=%b want 0 0", busy_a, wr_en_a); end
  endtask

  task automatic test_constant_frame();
    wq_a.delete(); ndone_a = 0;
    @(negedge clk);
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL busy_before_start: got %b want 0", busy_a); end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n_chk++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", busy_a); end
    // Changing the window inputs after the accepted start, plus a start pulse mid-capture, must not disturb it.
    win_x0 = 16'd0; win_y0 = 16'd0;
    drive_frame(0, 99, 325, 50, 274, 150, 3'b001);
    win_x0 = 16'd100; win_y0 = 16'd50;
    n_chk++; if (wq_a.size() != 784) begin n_fail++; $display("FAIL const_count: got %0d want 784", wq_a.size()); end
    for (int i = 0; i < wq_a.size(); i++) begin
      n_chk++;
      if (wq_a[i].addr != i || wq_a[i].data != int'(bin(8'h80)) || wq_a[i].done != int'(i == 783)) begin
        n_fail++;
        $display("FAIL const_write[%0d]: got addr=%0d data=%h done=%0d want addr=%0d data=%h done=%0d",
                 i, wq_a[i].addr, wq_a[i].data, wq_a[i].done, i, bin(8'h80), int'(i == 783));
        break;
      end
    end
    n_chk++; if (ndone_a != 1) begin n_fail++; $display("FAIL const_done_count: got %0d want 1", ndone_a); end
    n_chk++; if (busy_at_done_a !== 1'b1) begin n_fail++; $display("FAIL busy_at_done: got %b want 1", busy_at_done_a); end
    n_chk++; if (busy_after_done_a !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %b want 0", busy_after_done_a); end
    drive_frame(0, 99, 325, 50, 61, -1, 3'b000);
    n_chk++; if (wq_a.size() != 784 || ndone_a != 1) begin
      n_fail++; $display("FAIL second_frame_quiet: writes=%0d done=%0d want 784 1", wq_a.size(), ndone_a); end
  endtask

  task automatic test_block_pattern(input int pat, input logic [7:0] e0, input logic [7:0] e1,
                                    input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_d [4];
    exp_d[0] = bin(e0); exp_d[1] = bin(e1); exp_d[2] = bin(e2); exp_d[3] = bin(e3);
    wq_m.delete(); ndone_m = 0;
    pulse_start(1);
    drive_frame(pat, 98, 118, 50, 68, -1, 3'b000);
    n_chk++; if (wq_m.size() != 4 || ndone_m != 1) begin
      n_fail++; $display("FAIL pat%0d_count: writes=%0d done=%0d want 4 1", pat, wq_m.size(), ndone_m); end
    for (int i = 0; i < wq_m.size() && i < 4; i++) begin
      n_chk++;
      if (wq_m[i].addr != i || wq_m[i].data != int'(exp_d[i]) || wq_m[i].done != int'(i == 3)) begin
        n_fail++;
        $display("FAIL pat%0d_write[%0d]: got addr=%0d data=%h done=%0d want addr=%0d data=%h done=%0d",
                 pat, i, wq_m[i].addr, wq_m[i].data, wq_m[i].done, i, exp_d[i], int'(i == 3));
      end
    end
  endtask

  task automatic test_mid_frame_start();
    wq_m.delete(); ndone_m = 0;
    drive_frame(0, 98, 118, 44, 68, 58, 3'b010);
    n_chk++; if (wq_m.size() != 0 || busy_m !== 1'b1) begin
      n_fail++; $display("FAIL midstart_partial: writes=%0d busy=%b want 0 1", wq_m.size(), busy_m); end
    drive_frame(0, 98, 118, 44, 68, -1, 3'b000);
    n_chk++; if (wq_m.size() != 4 || ndone_m != 1) begin
      n_fail++; $display("FAIL midstart_next: writes=%0d done=%0d want 4 1", wq_m.size(), ndone_m); end
    for (int i = 0; i < wq_m.size() && i < 4; i++) begin
      n_chk++;
      if (wq_m[i].addr != i || wq_m[i].data != int'(bin(8'h80))) begin
        n_fail++; $display("FAIL midstart_write[%0d]: got addr=%0d data=%h want %0d %h",
                           i, wq_m[i].addr, wq_m[i].data, i, bin(8'h80));
      end
    end
  endtask

  task automatic test_reset_mid_capture();
    wq_m.delete(); ndone_m = 0;
    pulse_start(1);
    drive_frame(1, 98, 118, 50, 58, -1, 3'b000);
    n_chk++; if (wq_m.size() != 2 || busy_m !== 1'b1 || wr_data_m !== bin(8'hFF)) begin
      n_fail++; $display("FAIL rstmid_before: writes=%0d busy=%b data=%h want 2 1 %h",
                         wq_m.size(), busy_m, wr_data_m, bin(8'hFF)); end
    rst_m = 1'b0;
    #1;
    n_chk++; if ({busy_m, done_m, wr_en_m, wr_addr_m, wr_data_m} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %b want 0", {busy_m, done_m, wr_en_m, wr_addr_m, wr_data_m}); end
    @(negedge clk);
    rst_m = 1'b1;
    wq_m.delete();
    drive_frame(1, 98, 118, 50, 68, -1, 3'b000);
    drive_frame(1, 98, 118, 50, 68, -1, 3'b000);
    n_chk++; if (wq_m.size() != 0 || busy_m !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after: writes=%0d busy=%b want 0 0", wq_m.size(), busy_m); end
  endtask

  task automatic test_param_sweep(input logic partial_first);
    wq_s.delete(); ndone_s = 0;
    pulse_start(2);
    // A half frame first leaves dirty accumulators that the origin restart must flush.
    if (partial_first) drive_frame(0, 99, 109, 50, 51, -1, 3'b000);
    drive_frame(3, 99, 109, 50, 57, -1, 3'b000);
    n_chk++; if (wq_s.size() != 12 || ndone_s != 1) begin
      n_fail++; $display("FAIL sweep%0d_count: writes=%0d done=%0d want 12 1", partial_first, wq_s.size(), ndone_s); end
    for (int i = 0; i < wq_s.size() && i < 12; i++) begin
      logic [7:0] e;
      e = bin(2*(i % 4) + 2*(i / 4) + 1);
      n_chk++;
      if (wq_s[i].addr != i || wq_s[i].data != int'(e) || wq_s[i].done != int'(i == 11)) begin
        n_fail++;
        $display("FAIL sweep%0d_write[%0d]: got addr=%0d data=%h done=%0d want addr=%0d data=%h done=%0d",
                 partial_first, i, wq_s[i].addr, wq_s[i].data, wq_s[i].done, i, e, int'(i == 11));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_constant_frame();
    test_block_pattern(1, 8'h00, 8'hFF, 8'hFF, 8'h00);
    test_block_pattern(2, 8'h3F, 8'h3F, 8'h40, 8'h00);
    test_mid_frame_start();
    test_reset_mid_capture();
    test_param_sweep(1'b0);
    test_param_sweep(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
